// File: rtl/disp_arbiter.sv
// Round-robin arbiter sharing the 8-digit display between 4 requesters with a minimum grant dwell.
// Optional macro DISP_ARB_PRIO0_EN makes requester 0 a preempting priority requester.
module disp_arbiter #(
    parameter int DWELL = 50_000_000,
    parameter int CNT_W = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] data3,
    output logic [3:0]  grant,
    output logic [1:0]  cur_id,
    output logic [31:0] disp_d,
    output logic        disp_en,
    output logic        switch_p
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        cur_id_q, cur_id_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       disp_d_q, disp_d_d;
    logic              disp_en_q, disp_en_d;
    logic              switch_q, switch_d;

    logic              nw_found;
    logic [1:0]        nw_id;
    logic [1:0]        scan_idx;
    logic [31:0]       data_sel;
    logic              rearb;

    // Scan starts just after the pointer; the pointer itself (current owner) is visited last.
    always_comb begin
        nw_found = 1'b0;
        nw_id    = ptr_q;
        scan_idx = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!nw_found && req[scan_idx]) begin
                nw_found = 1'b1;
                nw_id    = scan_idx;
            end
        end
`ifdef DISP_ARB_PRIO0_EN
        if (req[0]) begin
            nw_found = 1'b1;
            nw_id    = 2'd0;
        end
`endif
    end

    always_comb begin
        case (cur_id_q)
            2'd0:    data_sel = data0;
            2'd1:    data_sel = data1;
            2'd2:    data_sel = data2;
            default: data_sel = data3;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cur_id_d  = cur_id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        disp_d_d  = disp_d_q;
        disp_en_d = disp_en_q;
        switch_d  = 1'b0;
        rearb     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    rearb = 1'b1;
                end
            end
            GRANT: begin
                disp_d_d = data_sel;
`ifdef DISP_ARB_PRIO0_EN
                if (req[0] && (cur_id_q != 2'd0)) begin
                    rearb = 1'b1;
                end else if (req[0]) begin
                    // Priority owner ignores the dwell entirely.
                    cnt_d = '0;
                end else
`endif
                if (!req[cur_id_q] || (cnt_q == CNT_LAST)) begin
                    rearb = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rearb) begin
            if (nw_found) begin
                state_d   = GRANT;
                grant_d   = 4'b0001 << nw_id;
                cur_id_d  = nw_id;
                ptr_d     = nw_id;
                cnt_d     = '0;
                disp_en_d = 1'b1;
                switch_d  = (state_q == IDLE) || (nw_id != cur_id_q);
            end else begin
                // Going idle: disp_d and cur_id keep their last values.
                state_d   = IDLE;
                grant_d   = 4'b0000;
                cnt_d     = '0;
                disp_en_d = 1'b0;
                switch_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            cur_id_q  <= 2'd0;
            ptr_q     <= 2'd3;
            cnt_q     <= '0;
            disp_d_q  <= 32'h0;
            disp_en_q <= 1'b0;
            switch_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cur_id_q  <= cur_id_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            disp_d_q  <= disp_d_d;
            disp_en_q <= disp_en_d;
            switch_q  <= switch_d;
        end
    end

    assign grant    = grant_q;
    assign cur_id   = cur_id_q;
    assign disp_d   = disp_d_q;
    assign disp_en  = disp_en_q;
    assign switch_p = switch_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter (DWELL=4); per-edge expectations queued at drive time, checked after the edge.
module tb_disp_arbiter;

    localparam logic [31:0] D0 = 32'hA0A0_A0A0;
    localparam logic [31:0] D1 = 32'h1111_1111;
    localparam logic [31:0] D2 = 32'h2222_2222;
    localparam logic [31:0] D3 = 32'h3333_3333;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] data0 = D0, data1 = D1, data2 = D2, data3 = D3;
    logic [3:0]  grant;
    logic [1:0]  cur_id;
    logic [31:0] disp_d;
    logic        disp_en;
    logic        switch_p;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [3:0]  g;
        logic        en;
        logic        sw;
        logic [1:0]  id;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];

    disp_arbiter #(.DWELL(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .grant(grant), .cur_id(cur_id), .disp_d(disp_d),
        .disp_en(disp_en), .switch_p(switch_p)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dword(input logic [1:0] i);
        case (i)
            2'd0:    return D0;
            2'd1:    return D1;
            2'd2:    return D2;
            default: return D3;
        endcase
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
            $error("%s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, queue what the outputs must be after the next edge, then check.
    task automatic step(input string tag, input logic rs, input logic [3:0] r,
                        input logic [3:0] eg, input logic een, input logic esw,
                        input logic [1:0] eid, input logic [31:0] ed);
        exp_t e;
        exp_t o;
        @(negedge clk);
        rst = rs;
        req = r;
        e.tag = tag; e.g = eg; e.en = een; e.sw = esw; e.id = eid; e.d = ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        cmp({o.tag, ".grant"},    32'(grant),    32'(o.g));
        cmp({o.tag, ".disp_en"},  32'(disp_en),  32'(o.en));
        cmp({o.tag, ".switch_p"}, 32'(switch_p), 32'(o.sw));
        cmp({o.tag, ".cur_id"},   32'(cur_id),   32'(o.id));
        cmp({o.tag, ".disp_d"},   disp_d,        o.d);
    endtask

    initial begin
        logic [1:0] own;
        logic [1:0] prev;

        // Reset held with all requests pending.
        step("rst0", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
        step("rst1", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
        step("rel_e1", 1'b0, 4'b1111, 4'b0001, 1'b1, 1'b1, 2'd0, 32'h0);
        step("rel_e2", 1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0, 2'd0, D0);

        // Rotation between 1 and 3, four cycles each; owner 0 drops first.
        prev = 2'd0;
        own  = 2'd1;
        for (int r = 0; r < 4; r++) begin
            step("rot_sw", 1'b0, 4'b1010, 4'b0001 << own, 1'b1, 1'b1, own, dword(prev));
            for (int c = 0; c < 3; c++)
                step("rot_hold", 1'b0, 4'b1010, 4'b0001 << own, 1'b1, 1'b0, own, dword(own));
            prev = own;
            own  = (own == 2'd1) ? 2'd3 : 2'd1;
        end

        // Lone requester re-granted across dwell boundaries without a gap.
        step("lone_sw", 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, D3);
        for (int c = 0; c < 19; c++)
            step("lone_hold", 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 2'd2, D2);

        // Owner 1 drops at dwell cycle 1 while 2 waits, then everyone leaves.
        step("drop_g1", 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, D2);
        step("drop_c1", 1'b0, 4'b0110, 4'b0010, 1'b1, 1'b0, 2'd1, D1);
        step("drop_g2", 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, D1);
        step("drop_d2", 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 2'd2, D2);
        step("idle_in", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, D2);
        data2 = 32'hDEAD_BEEF;
        step("idle_hold", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, D2);
        data2 = D2;

        // Reset in the middle of requester 3's dwell.
        step("mr_g3", 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, D2);
        step("mr_c1", 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, 2'd3, D3);
        step("mr_c2", 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, 2'd3, D3);
        step("mr_rst", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
        step("mr_rel", 1'b0, 4'b1111, 4'b0001, 1'b1, 1'b1, 2'd0, 32'h0);
        step("mr_d0", 1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0, 2'd0, D0);

        // Requester 0 rises at counter 1 while 1 owns the display.
        step("p_g1", 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, D0);
        step("p_c1", 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 2'd1, D1);
`ifdef DISP_ARB_PRIO0_EN
        step("p_pre", 1'b0, 4'b0011, 4'b0001, 1'b1, 1'b1, 2'd0, D1);
        for (int c = 0; c < 12; c++)
            step("p_hold", 1'b0, 4'b0011, 4'b0001, 1'b1, 1'b0, 2'd0, D0);
        step("p_rel", 1'b0, 4'b0110, 4'b0010, 1'b1, 1'b1, 2'd1, D0);
`else
        step("np_c2", 1'b0, 4'b0011, 4'b0010, 1'b1, 1'b0, 2'd1, D1);
        step("np_c3", 1'b0, 4'b0011, 4'b0010, 1'b1, 1'b0, 2'd1, D1);
        step("np_rot", 1'b0, 4'b0011, 4'b0001, 1'b1, 1'b1, 2'd0, D1);
        step("np_d0", 1'b0, 4'b0011, 4'b0001, 1'b1, 1'b0, 2'd0, D0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
